// File: rtl/pcpi_result_tx.sv
// pcpi_result_tx
// Return path for the fused matrix-multiply PCPI unit. Each 32-bit result
// captured from the PCPI write-back port is streamed to the host as nibbles,
// LS nibble first, using a 4-phase valid/ack handshake.
// Build option: define PCPI_TX_PENDING_EN to add a one-entry pending buffer
// that holds a result arriving while the previous word is still draining.
// WORD_W must be a multiple of NIB_W.
module pcpi_result_tx #(
  parameter int WORD_W = 32,
  parameter int NIB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcpi_ready,
  input  logic              pcpi_wr,
  input  logic [WORD_W-1:0] pcpi_rd,
  input  logic              out_ack,
  output logic              out_valid,
  output logic [NIB_W-1:0]  out_nibble,
  output logic              busy,
  output logic              pending_full,
  output logic              overflow
);

  localparam int NIBS  = WORD_W / NIB_W;
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_sr;
  logic [IDX_W-1:0]  r_idx;
  logic              r_out_valid;
  logic [NIB_W-1:0]  r_out_nibble;
  logic              r_busy;
  logic              r_overflow;

  logic              w_cap;
  logic              w_final_rel;
  logic              w_absorb;
  logic              w_drop;
  logic              w_pend_full;
  logic [WORD_W-1:0] w_pend_word;
  logic [WORD_W-1:0] w_sr_shift;

  // A result is only taken when the completion strobe qualifies the write-back.
  assign w_cap = pcpi_ready & pcpi_wr;

  // Final-release cycle: last nibble's ack has just dropped, so the shift
  // register is free this very cycle and can take a new word directly.
  assign w_final_rel = (r_state == ST_RELEASE) & ~out_ack & (r_idx == IDX_LAST);

  // Results arriving while the serializer is occupied (outside the
  // final-release cycle) must be buffered or dropped.
  assign w_absorb = w_cap & (r_state != ST_IDLE) & ~w_final_rel;

  assign w_sr_shift = r_sr >> NIB_W;

`ifdef PCPI_TX_PENDING_EN
  logic              r_pend_full;
  logic [WORD_W-1:0] r_pend;

  // Pending slot: refilled by a concurrent capture when it hands its word to
  // the serializer, otherwise filled by a busy-time capture if empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_full <= 1'b0;
      r_pend      <= {WORD_W{1'b0}};
    end else if (w_final_rel && r_pend_full) begin
      r_pend_full <= w_cap;
      r_pend      <= pcpi_rd;
    end else if (w_absorb && !r_pend_full) begin
      r_pend_full <= 1'b1;
      r_pend      <= pcpi_rd;
    end else begin
      r_pend_full <= r_pend_full;
      r_pend      <= r_pend;
    end
  end

  assign w_pend_full = r_pend_full;
  assign w_pend_word = r_pend;
  assign w_drop      = w_absorb & r_pend_full;
`else
  assign w_pend_full = 1'b0;
  assign w_pend_word = {WORD_W{1'b0}};
  assign w_drop      = w_absorb;
`endif

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // Serializer FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sr         <= {WORD_W{1'b0}};
      r_idx        <= IDX_ZERO;
      r_out_valid  <= 1'b0;
      r_out_nibble <= {NIB_W{1'b0}};
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cap) begin
            r_state      <= ST_PRESENT;
            r_sr         <= pcpi_rd;
            r_idx        <= IDX_ZERO;
            r_out_valid  <= 1'b1;
            r_out_nibble <= pcpi_rd[NIB_W-1:0];
            r_busy       <= 1'b1;
          end else begin
            r_out_valid  <= 1'b0;
            r_out_nibble <= {NIB_W{1'b0}};
            r_busy       <= 1'b0;
          end
        end

        ST_PRESENT: begin
          if (out_ack) begin
            r_state     <= ST_RELEASE;
            r_out_valid <= 1'b0;
          end else begin
            r_out_valid <= 1'b1;
          end
        end

        ST_RELEASE: begin
          if (out_ack) begin
            // Host still holding ack high: wait here indefinitely.
            r_out_valid <= 1'b0;
          end else if (r_idx != IDX_LAST) begin
            r_state      <= ST_PRESENT;
            r_sr         <= w_sr_shift;
            r_idx        <= r_idx + IDX_ONE;
            r_out_valid  <= 1'b1;
            r_out_nibble <= w_sr_shift[NIB_W-1:0];
          end else if (w_pend_full) begin
            r_state      <= ST_PRESENT;
            r_sr         <= w_pend_word;
            r_idx        <= IDX_ZERO;
            r_out_valid  <= 1'b1;
            r_out_nibble <= w_pend_word[NIB_W-1:0];
          end else if (w_cap) begin
            r_state      <= ST_PRESENT;
            r_sr         <= pcpi_rd;
            r_idx        <= IDX_ZERO;
            r_out_valid  <= 1'b1;
            r_out_nibble <= pcpi_rd[NIB_W-1:0];
          end else begin
            r_state      <= ST_IDLE;
            r_idx        <= IDX_ZERO;
            r_out_valid  <= 1'b0;
            r_out_nibble <= {NIB_W{1'b0}};
            r_busy       <= 1'b0;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_idx        <= IDX_ZERO;
          r_out_valid  <= 1'b0;
          r_out_nibble <= {NIB_W{1'b0}};
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid    = r_out_valid;
  assign out_nibble   = r_out_nibble;
  assign busy         = r_busy;
  assign pending_full = w_pend_full;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_pcpi_result_tx.sv
// Testbench for pcpi_result_tx: table-driven words streamed through a host
// handshake model, with a nibble scoreboard and hand-written corner cases.
// Pending-buffer sequences are selected by PCPI_TX_PENDING_EN.
module tb_pcpi_result_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcpi_ready = 1'b0;
  logic        pcpi_wr = 1'b0;
  logic [31:0] pcpi_rd = 32'h0;
  logic        out_ack = 1'b0;
  logic        out_valid;
  logic [3:0]  out_nibble;
  logic        busy;
  logic        pending_full;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];

  typedef struct {
    logic [31:0] word;
    logic [3:0]  exp_nib0;
    int          hold_idx;
    int          hold_cyc;
  } vec_t;

  vec_t vecs[5];

  pcpi_result_tx #(.WORD_W(32), .NIB_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pcpi_ready   (pcpi_ready),
    .pcpi_wr      (pcpi_wr),
    .pcpi_rd      (pcpi_rd),
    .out_ack      (out_ack),
    .out_valid    (out_valid),
    .out_nibble   (out_nibble),
    .busy         (busy),
    .pending_full (pending_full),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one result on the PCPI port for a single cycle.
  task automatic send(input logic [31:0] w, input bit push);
    pcpi_ready = 1'b1;
    pcpi_wr    = 1'b1;
    pcpi_rd    = w;
    if (push) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(w[4*i +: 4]);
    end
    tick();
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
  endtask

  // One full 4-phase handshake; optionally capture a word while ack drops.
  task automatic host_nibble(input int hold, input bit cap_en, input logic [31:0] cap_word);
    int t;
    logic [3:0] e;
    t = 0;
    while (out_valid !== 1'b1 && t < 40) begin
      tick();
      t++;
    end
    if (out_valid !== 1'b1) begin
      check("valid_timeout", {31'h0, out_valid}, 32'h1);
      return;
    end
    check("busy_while_valid", {31'h0, busy}, 32'h1);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_nibble: got %0h expected none", out_nibble);
    end else begin
      e = exp_q.pop_front();
      check("nibble", {28'h0, out_nibble}, {28'h0, e});
    end
    out_ack = 1'b1;
    tick();
    check("valid_drop", {31'h0, out_valid}, 32'h0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("valid_held_low", {31'h0, out_valid}, 32'h0);
      check("busy_held", {31'h0, busy}, 32'h1);
    end
    if (cap_en) begin
      pcpi_ready = 1'b1;
      pcpi_wr    = 1'b1;
      pcpi_rd    = cap_word;
      for (int i = 0; i < 8; i++) exp_q.push_back(cap_word[4*i +: 4]);
    end
    out_ack = 1'b0;
    tick();
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    if (exp_q.size() > 0) check("next_nibble_valid", {31'h0, out_valid}, 32'h1);
    else                  check("busy_fall", {31'h0, busy}, 32'h0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) host_nibble(0, 1'b0, 32'h0);
  endtask

  // Global time bound so a stuck DUT cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h89ABCDEF, 4'hF, -1, 0};
    vecs[1] = '{32'h12345678, 4'h8,  3, 9};
    vecs[2] = '{32'hFFFFFFFF, 4'hF, -1, 0};
    vecs[3] = '{32'h00000000, 4'h0,  7, 2};
    vecs[4] = '{32'hA5A55A5A, 4'hA,  0, 1};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_valid",   {31'h0, out_valid},    32'h0);
    check("rst_nibble",  {28'h0, out_nibble},   32'h0);
    check("rst_busy",    {31'h0, busy},         32'h0);
    check("rst_pending", {31'h0, pending_full}, 32'h0);
    check("rst_ovf",     {31'h0, overflow},     32'h0);
    rst = 1'b0;
    tick();

    // Unqualified strobes are ignored
    pcpi_wr = 1'b1; pcpi_rd = 32'hDEAD0001;
    tick();
    check("wr_only_ignored", {31'h0, busy}, 32'h0);
    pcpi_wr = 1'b0; pcpi_ready = 1'b1;
    tick();
    check("ready_only_ignored", {31'h0, busy}, 32'h0);
    pcpi_ready = 1'b0;
    tick();

    // Table-driven words, some with a prolonged ack-high phase
    for (int v = 0; v < 5; v++) begin
      send(vecs[v].word, 1'b1);
      check("start_valid", {31'h0, out_valid}, 32'h1);
      check("start_busy",  {31'h0, busy},      32'h1);
      check("start_nib0",  {28'h0, out_nibble}, {28'h0, vecs[v].exp_nib0});
      for (int i = 0; i < 8; i++)
        host_nibble((i == vecs[v].hold_idx) ? vecs[v].hold_cyc : 0, 1'b0, 32'h0);
      check("table_ovf", {31'h0, overflow}, 32'h0);
      tick();
      check("table_idle_nibble", {28'h0, out_nibble}, 32'h0);
    end

    // Capture coinciding with the final-release cycle goes straight to SR
    send(32'h0F1E2D3C, 1'b1);
    drain(7);
    host_nibble(0, 1'b1, 32'h76543210);
    drain(8);
    check("final_rel_ovf",  {31'h0, overflow}, 32'h0);
    check("final_rel_idle", {31'h0, busy},     32'h0);

`ifdef PCPI_TX_PENDING_EN
    // Second result parked in pending, streamed with no idle gap
    send(32'h11111111, 1'b1);
    host_nibble(0, 1'b0, 32'h0);
    send(32'h22222222, 1'b1);
    check("pend_set", {31'h0, pending_full}, 32'h1);
    drain(15);
    check("pend_ovf",   {31'h0, overflow},     32'h0);
    check("pend_clear", {31'h0, pending_full}, 32'h0);

    // Final release with pending full: pending -> SR, new word -> pending
    send(32'h33333333, 1'b1);
    send(32'h44444444, 1'b1);
    check("pend_full2", {31'h0, pending_full}, 32'h1);
    drain(7);
    host_nibble(0, 1'b1, 32'h55555555);
    check("pend_refill", {31'h0, pending_full}, 32'h1);
    check("refill_ovf",  {31'h0, overflow},     32'h0);
    drain(16);
    check("refill_pend_clear", {31'h0, pending_full}, 32'h0);

    // Three back-to-back results: third is dropped
    send(32'h66666666, 1'b1);
    send(32'h77777777, 1'b1);
    send(32'h88888888, 1'b0);
    check("drop_ovf",  {31'h0, overflow},     32'h1);
    check("drop_pend", {31'h0, pending_full}, 32'h1);
    drain(16);
    check("drop_ovf_sticky", {31'h0, overflow}, 32'h1);
    check("drop_idle",       {31'h0, busy},     32'h0);
`else
    // No pending storage: busy-time result is dropped
    send(32'h99999999, 1'b1);
    send(32'hBBBBBBBB, 1'b0);
    check("nopend_ovf",  {31'h0, overflow},     32'h1);
    check("nopend_pend", {31'h0, pending_full}, 32'h0);
    drain(7);
    host_nibble(0, 1'b1, 32'hCCCCCCCC);
    drain(8);
    check("nopend_ovf_sticky", {31'h0, overflow}, 32'h1);
    check("nopend_idle",       {31'h0, busy},     32'h0);
`endif

    // Reset mid-transfer aborts the word (and any pending one)
    send(32'hDEADBEEF, 1'b1);
`ifdef PCPI_TX_PENDING_EN
    send(32'h13579BDF, 1'b0);
    check("abort_pend_full", {31'h0, pending_full}, 32'h1);
`endif
    drain(5);
    check("abort_nib5_valid", {31'h0, out_valid}, 32'h1);
    rst = 1'b1;
    tick();
    check("abort_valid",   {31'h0, out_valid},    32'h0);
    check("abort_nibble",  {28'h0, out_nibble},   32'h0);
    check("abort_busy",    {31'h0, busy},         32'h0);
    check("abort_pending", {31'h0, pending_full}, 32'h0);
    check("abort_ovf",     {31'h0, overflow},     32'h0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    send(32'h0000000A, 1'b1);
    check("fresh_nib0", {28'h0, out_nibble}, 32'hA);
    drain(8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_abort_quiet", {31'h0, out_valid}, 32'h0);
    end
    check("queue_empty", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
